// File: rtl/karatsuba32_arb_pkg.sv
// Shared constants, state encoding and width helper for the karatsuba32
// multiplier arbiter.
package karatsuba32_arb_pkg;

  localparam int OP_W = 32;
  localparam int P_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to index v values; never less than 1 so a 1-deep counter still has a bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/karatsuba32.sv
// Combinational 32x32 unsigned multiplier built from one level of Karatsuba
// decomposition over 16-bit halves.
module karatsuba32 (
  output logic [63:0] P,
  input  logic [31:0] A,
  input  logic [31:0] B
);

  logic [15:0] w_ah, w_al, w_bh, w_bl;
  logic [16:0] w_sa, w_sb;
  logic [31:0] w_z0, w_z2;
  logic [33:0] w_zm, w_z1;

  assign w_ah = A[31:16];
  assign w_al = A[15:0];
  assign w_bh = B[31:16];
  assign w_bl = B[15:0];
  assign w_sa = {1'b0, w_ah} + {1'b0, w_al};
  assign w_sb = {1'b0, w_bh} + {1'b0, w_bl};
  assign w_z2 = w_ah * w_bh;
  assign w_z0 = w_al * w_bl;
  assign w_zm = 34'(w_sa) * 34'(w_sb);
  // Middle term (ah*bl + al*bh) recovered from the cross-sum product.
  assign w_z1 = w_zm - 34'(w_z2) - 34'(w_z0);
  assign P = {w_z2, 32'b0} + {14'b0, w_z1, 16'b0} + {32'b0, w_z0};

endmodule

// File: rtl/karatsuba32_arbiter_rr_grant.sv
// Round-robin grant: first set request bit at or after ptr, wrapping around.
module rr_grant
  import karatsuba32_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/karatsuba32_arbiter.sv
// Shares one combinational karatsuba32 between N_REQ requesters: one product in
// flight, operands held for SETTLE_CYCLES before the product is captured.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; req_ready is a combinational one-hot grant, rsp_valid stays asserted with
// rsp_p stable until the owning requester's rsp_ready is seen.
module karatsuba32_arbiter
  import karatsuba32_arb_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [OP_W*N_REQ-1:0] req_a,
  input  logic [OP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [P_W-1:0]        rsp_p,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int CNT_W = clog2(SETTLE_CYCLES);

  state_t           r_state, w_next_state;
  logic [IDX_W-1:0] r_rr_ptr, r_owner, w_grant_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_op_a, r_op_b;
  logic [P_W-1:0]   r_rsp_p, w_mul_p;
  logic [N_REQ-1:0] w_grant;
  logic             w_hs, w_rsp_done, w_cnt_zero;

  rr_grant #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_grant (
    .req      (req_valid),
    .ptr      (r_rr_ptr),
    .grant    (w_grant),
    .grant_idx(w_grant_idx)
  );

  karatsuba32 u_mul (
    .P(w_mul_p),
    .A(r_op_a),
    .B(r_op_b)
  );

  assign w_hs       = (r_state == ST_IDLE) && !rst && |(req_valid & w_grant);
  assign w_rsp_done = (r_state == ST_DONE) && rsp_ready[r_owner];
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_hs) w_next_state = ST_BUSY;
      ST_BUSY: if (w_cnt_zero) w_next_state = ST_DONE;
      ST_DONE: if (w_rsp_done) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (r_state == ST_IDLE && !rst) req_ready = w_grant;
    if (r_state == ST_DONE) rsp_valid[r_owner] = 1'b1;
    busy      = (r_state != ST_IDLE);
    rsp_p     = r_rsp_p;
    dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_rsp_p  <= '0;
    end else begin
      if (w_hs) begin
        r_op_a  <= req_a[w_grant_idx*OP_W +: OP_W];
        r_op_b  <= req_b[w_grant_idx*OP_W +: OP_W];
        r_owner <= w_grant_idx;
        r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
      end
      if (r_state == ST_BUSY) begin
        if (w_cnt_zero) r_rsp_p <= w_mul_p;
        else            r_cnt   <= r_cnt - 1'b1;
      end
      // Next search starts just past the requester that was served.
      if (w_rsp_done)
        r_rr_ptr <= (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
    end
  end

endmodule

// File: doc/karatsuba32_arbiter.md
# karatsuba32_arbiter

Sequencer and round-robin arbiter that shares one combinational `karatsuba32` multiplier instance between `N_REQ` requesters. It accepts one operand pair per handshake and registers the operands into the multiplier. It waits a fixed number of settle cycles for the deep combinational path, captures the 64-bit product, and returns it to the requester that issued the operation. It sits between the multiply clients and the multiplier, so only one product is ever in flight.

## Interface
- `N_REQ`, default 2: number of requesters; valid range 2..8.
- `SETTLE_CYCLES`, default 2: cycles the operand registers are held before the product is captured; minimum 1.
- `clk` input, 1 bit: single clock, all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, `N_REQ` bits: requester i has an operand pair pending.
- `req_ready` output, `N_REQ` bits: one-hot grant; a handshake occurs when `req_valid[i] && req_ready[i]`.
- `req_a` input, 32·`N_REQ` bits: operand A of requester i, in bits [32i+31:32i], unsigned.
- `req_b` input, 32·`N_REQ` bits: operand B of requester i, in bits [32i+31:32i], unsigned.
- `rsp_valid` output, `N_REQ` bits: one-hot; the product for requester i is on `rsp_p`.
- `rsp_ready` input, `N_REQ` bits: requester i consumes the response.
- `rsp_p` output, 64 bits: captured product, shared by all requesters.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- The state machine has three states: IDLE, BUSY and DONE.
- **IDLE**
  - Grant is round-robin over `req_valid`, starting the search at pointer `rr_ptr`.
  - `req_ready` equals that grant; it is combinational from `req_valid` and is forced to 0 when the state is not IDLE or `rst` is high.
  - On a handshake from requester g: latch `req_a[g]` and `req_b[g]` into `op_a`/`op_b`, set `owner`=g, load `cnt`=`SETTLE_CYCLES`-1, and move to BUSY.
  - With no `req_valid` bit set, stay in IDLE.
- **BUSY**
  - `op_a`/`op_b` drive the multiplier inputs continuously.
  - When `cnt`==0: capture the multiplier output into `rsp_p` and move to DONE. Otherwise decrement `cnt`.
- **DONE**
  - `rsp_valid[owner]`=1, and `rsp_p` is held stable.
  - On `rsp_ready[owner]`: move to IDLE and set `rr_ptr` = (`owner`+1) mod `N_REQ`.
  - `rsp_ready` bits of non-owners are ignored.
- The product is the unmodified multiplier output. The arbiter does no arithmetic correction; in particular, no exact-product assumption is made for the approximate variant.
- `op_a`/`op_b` keep their last values while in IDLE; the multiplier output is don't-care there.

## Timing
- **Reset values:** state IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_p`=0, `busy`=0, `rr_ptr`=0, `owner`=0, `cnt`=0, `op_a`=`op_b`=0.
- **Latency:** handshake on edge t, BUSY during cycles t+1..t+`SETTLE_CYCLES`, `rsp_valid` high from cycle t+`SETTLE_CYCLES`+1.
- **Throughput:** with `rsp_ready` held high, one operation every `SETTLE_CYCLES`+2 cycles.
- **Response hold:** `rsp_valid` and `rsp_p` stay stable until consumed; backpressure holds the machine in DONE indefinitely.
- **Simultaneous requests:** only one grant per IDLE cycle. The rotating pointer guarantees each continuously-valid requester is served within `N_REQ` operations.
- **Requester i dropping `req_valid` before grant:** no operation is issued; this is legal.
- **`rsp_ready` with a new `req_valid` in the DONE cycle:** the new request cannot be granted in that cycle; it is granted in the following IDLE cycle.
- **`rst` mid-operation (BUSY or DONE):** the in-flight operation is discarded, no response is issued, and the next cycle is IDLE with all reset values.
- **`SETTLE_CYCLES`=1:** BUSY lasts exactly one cycle.

## Structure
- Package `karatsuba32_arb_pkg` holds:
  - the state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - `OP_W`=32 and `P_W`=64;
  - the `clog2` helper used for the `owner`, `rr_ptr` and `cnt` widths.
- Sub-module `rr_grant` is parameterised on `N_REQ`. It takes (`req`, `ptr`) and produces a one-hot `grant` plus the encoded `grant_idx`.
- The existing `karatsuba32` is instantiated once with port order (P,A,B); it is not modified.

## Test plan
- **Single request:** reset, then requester 0 sends A=65536, B=18 with `SETTLE_CYCLES`=2.
  - `rsp_valid[0]` rises 3 cycles after the handshake.
  - `rsp_p` equals a standalone `karatsuba32` instance fed the same operands (1179648 for an exact multiplier).
- **Simultaneous requests:** both requesters valid continuously, requester 0 with A=48584, B=54471 and requester 1 with A=0xFFFFFFFF, B=0xFFFFFFFF.
  - Grants alternate 0,1,0,1.
  - Each response matches the golden instance (2646419064 and 0xFFFFFFFE00000001 when exact).
  - There are 4 cycles between handshakes.
- **Backpressure:** hold `rsp_ready` low for 10 cycles in DONE.
  - `rsp_valid` and `rsp_p` stay stable, `req_ready` stays 0 and `busy` stays 1.
  - Releasing `rsp_ready` returns the machine to IDLE on the next edge.
- **Reset in BUSY:** assert `rst` for 1 cycle during BUSY.
  - No `rsp_valid` is ever seen for that operation, and all outputs hold their reset values the next cycle.
  - The next request completes normally.
- **Randomised soak:** 2000 random operand pairs on 2 requesters, with random `req_valid` and `rsp_ready` gaps.
  - Every accepted operation returns exactly one response, in order per requester, matching the golden instance.
  - There are no grant collisions.
